exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_pkg.sv | 29 ++
 rtl/mul_shift_add.sv | 56 +++++
 rtl/exec_stage.sv | 142 ++++++++++++++
 tb/tb_exec_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcode/state types and sizing for the execute stage
package exec_pkg;

    localparam int W_DEFAULT = 8;
    localparam int MUL_STEPS = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_MUL = 3'd6,
        OP_NOP = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Single-cycle ops write back straight from the combinational ALU.
    function automatic logic is_alu_op(input op_t o);
        return (o != OP_MUL) && (o != OP_NOP);
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// rtl/mul_shift_add.sv - iterative shift-add multiplier, fixed step count
module mul_shift_add
    import exec_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] prod_lo,
    output logic         prod_hi_nz
);

    // Multiplier bits consumed per step so the product completes in MUL_STEPS steps for any W.
    localparam int SB = (W + MUL_STEPS - 1) / MUL_STEPS;

    logic [2*W-1:0] mcand_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   mplier_q;

    always_comb begin
        acc_nxt = acc_q;
        if (step) begin
            for (int i = 0; i < SB; i++) begin
                if (mplier_q[i]) begin
                    acc_nxt = acc_nxt + (mcand_q << i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load) begin
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
        end else if (step) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << SB;
            mplier_q <= mplier_q >> SB;
        end
    end

    // Outputs include the step in flight so the caller can capture on the final step edge.
    assign prod_lo    = acc_nxt[W-1:0];
    assign prod_hi_nz = |acc_nxt[2*W-1:W];

endmodule

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: single-cycle ALU plus 8-step multiplier, one write-back per op
module exec_stage
    import exec_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [1:0]   rd_addr,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         busy,
    output logic         wb_en,
    output logic [1:0]   wb_addr,
    output logic [W-1:0] wb_data,
    output logic         zero,
    output logic         carry
);

    state_t       state_q;
    state_t       state_d;
    op_t          op_e;
    logic [2:0]   cnt_q;
    logic [1:0]   rd_q;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic         accept_alu;
    logic         accept_mul;
    logic         mul_step;
    logic         mul_done;
    logic [W-1:0] mul_lo;
    logic         mul_hi_nz;

    assign op_e = op_t'(op);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_e)
            OP_ADD: {alu_c, alu_res} = {1'b0, opA} + {1'b0, opB};
            OP_SUB: begin
                alu_res = opA - opB;
                alu_c   = (opA >= opB);
            end
            OP_AND: alu_res = opA & opB;
            OP_XOR: alu_res = opA ^ opB;
            OP_SHL: begin
                alu_res = opA << 1;
                alu_c   = opA[W-1];
            end
            OP_SHR: begin
                alu_res = opA >> 1;
                alu_c   = opA[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        accept_alu = 1'b0;
        accept_mul = 1'b0;
        mul_step   = 1'b0;
        mul_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_alu_op(op_e)) begin
                    accept_alu = 1'b1;
                    state_d    = WB;
                end else if (start && (op_e == OP_MUL)) begin
                    accept_mul = 1'b1;
                    state_d    = MUL;
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (cnt_q == 3'd7) begin
                    mul_done = 1'b1;
                    state_d  = WB;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-back registers only move on the edge entering WB, so they hold across idle and MUL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            rd_q    <= '0;
            wb_addr <= '0;
            wb_data <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
        end else begin
            if (accept_mul) begin
                rd_q  <= rd_addr;
                cnt_q <= '0;
            end else if (mul_step) begin
                cnt_q <= cnt_q + 3'd1;
            end

            if (accept_alu) begin
                wb_addr <= rd_addr;
                wb_data <= alu_res;
                zero    <= (alu_res == '0);
                carry   <= alu_c;
            end else if (mul_done) begin
                wb_addr <= rd_q;
                wb_data <= mul_lo;
                zero    <= (mul_lo == '0);
                carry   <= mul_hi_nz;
            end
        end
    end

    mul_shift_add #(.W(W)) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept_mul),
        .step       (mul_step),
        .a          (opA),
        .b          (opB),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    assign busy  = (state_q != IDLE);
    assign wb_en = (state_q == WB);

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - directed and randomized checks of exec_stage against an arithmetic model
module tb_exec_stage;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op_s;
    logic [1:0]   rd;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         wb_en;
    logic [1:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         zero;
    logic         carry;

    int checks = 0;
    int errors = 0;
    int exp_data = 0;
    int exp_addr = 0;
    int exp_zero = 0;
    int exp_carry = 0;

    exec_stage #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op_s),
        .rd_addr (rd),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .zero    (zero),
        .carry   (carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the arithmetic rules on plain integers.
    task automatic model(input int o, input int a, input int b, output int r, output int c);
        int p;
        r = 0;
        c = 0;
        case (o)
            0: begin p = a + b;      r = p % M;           c = (p >= M) ? 1 : 0; end
            1: begin r = (a - b + M) % M;                 c = (a >= b) ? 1 : 0; end
            2: r = a & b;
            3: r = a ^ b;
            4: begin r = (a * 2) % M;                     c = (a >= M / 2) ? 1 : 0; end
            5: begin r = a / 2;                           c = a % 2; end
            6: begin p = a * b;      r = p % M;           c = (p >= M) ? 1 : 0; end
            default: ;
        endcase
    endtask

    task automatic do_op(input bit sync, input int o, input int a, input int b, input int r,
                         input bit poke);
        int lat;
        int res;
        int cy;
        int pulses;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_wb_en", 32'(wb_en), 0);
        chk("hold_data", 32'(wb_data), exp_data);
        chk("hold_addr", 32'(wb_addr), exp_addr);
        chk("hold_zero", 32'(zero), exp_zero);
        chk("hold_carry", 32'(carry), exp_carry);
        start = 1'b1;
        op_s  = 3'(o);
        opA   = W'(a);
        opB   = W'(b);
        rd    = 2'(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_s  = 3'($urandom);
        opA   = W'($urandom);
        opB   = W'($urandom);
        rd    = 2'($urandom);
        if (o == 7) begin
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk);
                chk("nop_busy", 32'(busy), 0);
                chk("nop_wb_en", 32'(wb_en), 0);
            end
        end else begin
            lat = (o == 6) ? 9 : 1;
            model(o, a, b, res, cy);
            pulses = 0;
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                chk("op_busy", 32'(busy), 1);
                if (wb_en === 1'b1) pulses++;
                if (c == lat) begin
                    chk("wb_en", 32'(wb_en), 1);
                    chk("wb_addr", 32'(wb_addr), r);
                    chk("wb_data", 32'(wb_data), res);
                    chk("zero", 32'(zero), (res == 0) ? 1 : 0);
                    chk("carry", 32'(carry), cy);
                end
                if (poke) begin
                    start = (c >= 3 && c <= 5);
                    op_s  = 3'd0;
                end
            end
            start = 1'b0;
            chk("wb_pulses", pulses, 1);
            exp_data  = res;
            exp_addr  = r;
            exp_zero  = (res == 0) ? 1 : 0;
            exp_carry = cy;
        end
    endtask

    initial begin
        int pulses;
        int o;
        rst_n = 1'b0;
        start = 1'b0;
        op_s  = 3'd0;
        rd    = 2'd0;
        opA   = '0;
        opB   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_addr", 32'(wb_addr), 0);
        chk("rst_wb_data", 32'(wb_data), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_carry", 32'(carry), 0);

        // Release reset and present start in the same cycle: the first edge must accept it.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_op(0, 0, 'hF0, 'h20, 2, 0);
        chk("add_f0_20", 32'(wb_data), 'h10);

        do_op(1, 1, 'h05, 'h05, 0, 0);
        chk("sub_eq_zero", 32'(zero), 1);
        do_op(1, 1, 'h03, 'h04, 3, 0);
        chk("sub_lt_data", 32'(wb_data), 'hFF);
        chk("sub_lt_carry", 32'(carry), 0);

        do_op(1, 6, 'h0D, 'h0B, 1, 0);
        chk("mul_0d_0b", 32'(wb_data), 'h8F);
        do_op(1, 6, 'h10, 'h10, 0, 0);
        chk("mul_ovf_carry", 32'(carry), 1);
        do_op(1, 6, 'h07, 'h09, 2, 1);
        chk("mul_poked", 32'(wb_data), 'h3F);

        do_op(1, 4, 'h81, 'h00, 1, 0);
        chk("shl_81", 32'(wb_data), 'h02);
        do_op(1, 5, 'h01, 'h00, 2, 0);
        chk("shr_01_zero", 32'(zero), 1);
        do_op(1, 7, 'h12, 'h34, 3, 0);

        // Abort a multiply in its fourth cycle.
        @(posedge clk);
        #1;
        start = 1'b1;
        op_s  = 3'd6;
        opA   = W'('h0D);
        opB   = W'('h0B);
        rd    = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_wb_en", 32'(wb_en), 0);
        chk("abort_wb_addr", 32'(wb_addr), 0);
        chk("abort_wb_data", 32'(wb_data), 0);
        chk("abort_zero", 32'(zero), 0);
        chk("abort_carry", 32'(carry), 0);
        exp_data  = 0;
        exp_addr  = 0;
        exp_zero  = 0;
        exp_carry = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (wb_en !== 1'b0 || busy !== 1'b0) pulses++;
        end
        chk("abort_no_wb", pulses, 0);
        do_op(1, 0, 'h01, 'h01, 3, 0);
        chk("post_abort_add", 32'(wb_data), 'h02);

        for (int n = 0; n < 40; n++) begin
            o = int'($urandom_range(0, 7));
            do_op(1, o, int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        do_op(1, 7, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
